// File: rtl/sdf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdf_pkg : shared constants, state encoding and twiddle-select decode for   |
// |           the 3-stage radix-2 SDF NTT pipeline scheduler (N = 8).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sdf_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int OFF2  = 4;
    localparam int OFF3  = 6;
    localparam int LAT   = 7;
    localparam int FCNT_W = 3;

    localparam logic [LOG2N-1:0]  CNT_MAX    = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0]  ARM2       = LOG2N'(OFF2);
    localparam logic [LOG2N-1:0]  ARM3       = LOG2N'(OFF3);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(LAT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic       TW2_PSI2 = 1'b0;
    localparam logic       TW2_PSI6 = 1'b1;
    localparam logic [1:0] TW3_PSI1 = 2'b00;
    localparam logic [1:0] TW3_PSI5 = 2'b01;
    localparam logic [1:0] TW3_PSI3 = 2'b10;
    localparam logic [1:0] TW3_PSI7 = 2'b11;

    function automatic logic tw2_of(input logic [LOG2N-1:0] c);
        return (c >= LOG2N'(N / 2)) ? TW2_PSI6 : TW2_PSI2;
    endfunction

    function automatic logic [1:0] tw3_of(input logic [LOG2N-1:0] c);
        logic [1:0] r;
        case (c)
            3'd0, 3'd1: r = TW3_PSI1;
            3'd2, 3'd3: r = TW3_PSI5;
            3'd4, 3'd5: r = TW3_PSI3;
            default:    r = TW3_PSI7;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_stage_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdf_stage_seq : per-stage sample counter with arm-after-offset latch and   |
// |                 buffer in/out select decode.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sdf_stage_seq
    import sdf_pkg::*;
#(
    parameter int STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_arm,
    output logic [LOG2N-1:0] o_cnt,
    output logic             o_sel
);

    localparam int SEL_BIT = LOG2N - STAGE;

    logic [LOG2N-1:0] r_cnt;
    logic             r_armed;
    logic             w_go;

    // i_arm is the first-sample condition; once seen, the latch keeps the stage counting
    assign w_go = i_en & (r_armed | i_arm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (w_go) begin
            r_cnt   <= r_cnt + 1'b1;
            r_armed <= 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sel = r_cnt[SEL_BIT];

endmodule
`default_nettype wire

// File: rtl/sdf_ntt_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdf_ntt_scheduler : frame FSM, stage sequencers and valid/last pipe for    |
// |                     the N=8 SDF NTT. Optional stats: SDF_SCHED_STATS_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sdf_ntt_scheduler
    import sdf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_pipe_en,
    output logic        o_in_zero,
    output logic        o_bo_sel1,
    output logic        o_bi_sel1,
    output logic        o_bo_sel2,
    output logic        o_bi_sel2,
    output logic        o_bo_sel3,
    output logic        o_bi_sel3,
    output logic        o_tw2_sel,
    output logic [1:0]  o_tw3_sel,
    output logic        o_out_valid,
    output logic        o_out_last,
    output logic        o_done_tick
`ifdef SDF_SCHED_STATS_EN
    ,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_stall_cnt
`endif
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_last_seen;
    logic [LAT-1:0]    r_vld;
    logic [LAT-1:0]    r_lst;

    logic              w_flush;
    logic              w_ready;
    logic              w_fire;
    logic              w_pipe_en;
    logic              w_done;
    logic              w_cnt1_last;
    logic [LOG2N-1:0]  w_cnt1;
    logic [LOG2N-1:0]  w_cnt2;
    logic [LOG2N-1:0]  w_cnt3;
    logic              w_sel1;
    logic              w_sel2;
    logic              w_sel3;

    assign w_flush     = (r_state == ST_FLUSH);
    assign w_ready     = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_fire      = i_in_valid & w_ready;
    assign w_pipe_en   = w_fire | w_flush;
    assign w_cnt1_last = (w_cnt1 == CNT_MAX);
    assign w_done      = w_flush && (r_fcnt == FLUSH_LAST);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_fire) w_state_nx = ST_RUN;
            ST_RUN:   if (r_last_seen && !i_in_valid) w_state_nx = ST_FLUSH;
            ST_FLUSH: if (w_done) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fcnt      <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_fcnt      <= (w_flush && !w_done) ? r_fcnt + 1'b1 : '0;
            r_last_seen <= w_fire & w_cnt1_last;
        end
    end

    // Flush slots shift in zeros, so the pipe is empty again when FLUSH ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (w_pipe_en) begin
            r_vld <= {r_vld[LAT-2:0], w_fire};
            r_lst <= {r_lst[LAT-2:0], w_fire & w_cnt1_last};
        end
    end

    // Counters are cleared at FLUSH exit so every new frame restarts from exact phasing
    sdf_stage_seq #(.STAGE(1)) u_seq1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_pipe_en),
        .i_clr (w_done),
        .i_arm (1'b1),
        .o_cnt (w_cnt1),
        .o_sel (w_sel1)
    );

    sdf_stage_seq #(.STAGE(2)) u_seq2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_pipe_en),
        .i_clr (w_done),
        .i_arm (w_cnt1 == ARM2),
        .o_cnt (w_cnt2),
        .o_sel (w_sel2)
    );

    sdf_stage_seq #(.STAGE(3)) u_seq3 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_pipe_en),
        .i_clr (w_done),
        .i_arm (w_cnt1 == ARM3),
        .o_cnt (w_cnt3),
        .o_sel (w_sel3)
    );

    assign o_in_ready  = w_ready;
    assign o_pipe_en   = w_pipe_en;
    assign o_in_zero   = w_flush;
    assign o_bo_sel1   = w_sel1;
    assign o_bi_sel1   = w_sel1;
    assign o_bo_sel2   = w_sel2;
    assign o_bi_sel2   = w_sel2;
    assign o_bo_sel3   = w_sel3;
    assign o_bi_sel3   = w_sel3;
    assign o_tw2_sel   = tw2_of(w_cnt2);
    assign o_tw3_sel   = tw3_of(w_cnt3);
    assign o_out_valid = r_vld[LAT-1] & w_pipe_en;
    assign o_out_last  = r_lst[LAT-1] & w_pipe_en;
    assign o_done_tick = w_done;

`ifdef SDF_SCHED_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_stall_cnt;

    // The RUN cycle that decides the move to FLUSH is a frame end, not a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (o_out_last && (r_frame_cnt != 16'hFFFF))
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((r_state == ST_RUN) && !i_in_valid && !r_last_seen && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_stall_cnt = r_stall_cnt;
`else
    // statistics counters not built
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdf_ntt_scheduler.sv
`default_nettype none
// Directed scoreboard bench for sdf_ntt_scheduler; stats checks build with SDF_SCHED_STATS_EN.
module tb_sdf_ntt_scheduler;
    import sdf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready, o_pipe_en, o_in_zero;
    logic        o_bo_sel1, o_bi_sel1, o_bo_sel2, o_bi_sel2, o_bo_sel3, o_bi_sel3;
    logic        o_tw2_sel;
    logic [1:0]  o_tw3_sel;
    logic        o_out_valid, o_out_last, o_done_tick;
`ifdef SDF_SCHED_STATS_EN
    logic [15:0] o_frame_cnt, o_stall_cnt;
`endif

    always #5 clk = ~clk;

    sdf_ntt_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_pipe_en   (o_pipe_en),
        .o_in_zero   (o_in_zero),
        .o_bo_sel1   (o_bo_sel1),
        .o_bi_sel1   (o_bi_sel1),
        .o_bo_sel2   (o_bo_sel2),
        .o_bi_sel2   (o_bi_sel2),
        .o_bo_sel3   (o_bo_sel3),
        .o_bi_sel3   (o_bi_sel3),
        .o_tw2_sel   (o_tw2_sel),
        .o_tw3_sel   (o_tw3_sel),
        .o_out_valid (o_out_valid),
        .o_out_last  (o_out_last),
        .o_done_tick (o_done_tick)
`ifdef SDF_SCHED_STATS_EN
        ,
        .o_frame_cnt (o_frame_cnt),
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    typedef struct {
        int   due;
        logic last;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_steps, m_fires, m_flush;
    logic m_lastprev;
    int   cyc_no, n_out, n_last, n_done, t_fire0, t_done;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_steps    = 0;
        m_fires    = 0;
        m_flush    = 0;
        m_lastprev = 1'b0;
        sb.delete();
    endtask

    task automatic reset_counts();
        cyc_no  = 0;
        n_out   = 0;
        n_last  = 0;
        n_done  = 0;
        t_fire0 = -1;
        t_done  = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 16'(o_in_ready), 16'd1);
        chk({tag, "_pipe_en"}, 16'(o_pipe_en), 16'd0);
        chk({tag, "_in_zero"}, 16'(o_in_zero), 16'd0);
        chk({tag, "_sels"}, 16'({o_bo_sel1, o_bi_sel1, o_bo_sel2, o_bi_sel2, o_bo_sel3, o_bi_sel3}), 16'd0);
        chk({tag, "_tw"}, 16'({o_tw2_sel, o_tw3_sel}), 16'd0);
        chk({tag, "_out"}, 16'({o_out_valid, o_out_last, o_done_tick}), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One clock of stimulus: drive, compare against the spec model, then advance the model
    task automatic cyc(input logic v);
        logic e_flush, e_rdy, e_fire, e_pe, e_done, e_ov, e_last_in;
        int   c1, c2, c3;
        sb_t  ent;
        @(negedge clk);
        i_in_valid = v;
        #1;
        e_flush = (m_flush > 0);
        e_rdy   = !e_flush;
        e_fire  = v && e_rdy;
        e_pe    = e_fire || e_flush;
        e_done  = (m_flush == 1);
        c1 = m_steps % N;
        c2 = (m_steps >= OFF2) ? (m_steps - OFF2) % N : 0;
        c3 = (m_steps >= OFF3) ? (m_steps - OFF3) % N : 0;

        chk("in_ready", 16'(o_in_ready), 16'(e_rdy));
        chk("pipe_en", 16'(o_pipe_en), 16'(e_pe));
        chk("in_zero", 16'(o_in_zero), 16'(e_flush));
        chk("done_tick", 16'(o_done_tick), 16'(e_done));
        chk("sel1", 16'({o_bo_sel1, o_bi_sel1}), 16'({2{c1[2]}}));
        chk("sel2", 16'({o_bo_sel2, o_bi_sel2}), 16'({2{c2[1]}}));
        chk("sel3", 16'({o_bo_sel3, o_bi_sel3}), 16'({2{c3[0]}}));
        chk("tw2_sel", 16'(o_tw2_sel), 16'(c2 >= 4));
        chk("tw3_sel", 16'(o_tw3_sel), 16'(c3[2:1]));

        e_ov = e_pe && (sb.size() > 0) && (sb[0].due == m_steps);
        chk("out_valid", 16'(o_out_valid), 16'(e_ov));
        if (e_ov) begin
            ent = sb.pop_front();
            chk("out_last", 16'(o_out_last), 16'(ent.last));
        end else begin
            chk("out_last_idle", 16'(o_out_last), 16'd0);
        end
        if (o_out_valid) n_out++;
        if (o_out_last)  n_last++;
        if (o_done_tick) begin
            n_done++;
            t_done = cyc_no;
        end

        e_last_in = e_fire && ((m_fires % N) == N - 1);
        if (e_fire) begin
            if (t_fire0 < 0) t_fire0 = cyc_no;
            ent.due  = m_steps + LAT;
            ent.last = e_last_in;
            sb.push_back(ent);
            m_fires++;
        end
        if (e_pe) m_steps++;
        if (e_flush) begin
            m_flush--;
            if (m_flush == 0) begin
                m_steps = 0;
                m_fires = 0;
            end
        end else if (m_lastprev && !v) begin
            m_flush = LAT;
        end
        m_lastprev = e_last_in;
        cyc_no++;
    endtask

    initial begin
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        model_clear();
        reset_counts();
        repeat (2) @(negedge clk);
        do_reset();

        // single frame
        reset_counts();
        repeat (8) cyc(1'b1);
        repeat (12) cyc(1'b0);
        chk("t1_n_out", 16'(n_out), 16'd8);
        chk("t1_n_last", 16'(n_last), 16'd1);
        chk("t1_n_done", 16'(n_done), 16'd1);
        chk("t1_done_time", 16'(t_done - t_fire0), 16'd15);

        // two frames back to back
        reset_counts();
        repeat (16) cyc(1'b1);
        repeat (12) cyc(1'b0);
        chk("t2_n_out", 16'(n_out), 16'd16);
        chk("t2_n_last", 16'(n_last), 16'd2);
        chk("t2_n_done", 16'(n_done), 16'd1);

        // 3-cycle bubble at cnt1=5, then a source held waiting through FLUSH
        reset_counts();
        repeat (5) cyc(1'b1);
        repeat (3) cyc(1'b0);
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        repeat (7) cyc(1'b1);
        repeat (8) cyc(1'b1);
        repeat (10) cyc(1'b0);
        chk("t3_n_out", 16'(n_out), 16'd16);
        chk("t3_n_last", 16'(n_last), 16'd2);
        chk("t3_n_done", 16'(n_done), 16'd2);

        // continuous stream, select trace across three frames
        reset_counts();
        repeat (24) cyc(1'b1);
        repeat (10) cyc(1'b0);
        chk("t4_n_out", 16'(n_out), 16'd24);
        chk("t4_n_last", 16'(n_last), 16'd3);
        chk("t4_n_done", 16'(n_done), 16'd1);

        // reset mid-frame at cnt1=3
        reset_counts();
        repeat (3) cyc(1'b1);
        do_reset();
        repeat (10) cyc(1'b0);
        chk("t5_no_done", 16'(n_done), 16'd0);
        chk("t5_no_out", 16'(n_out), 16'd0);
        repeat (8) cyc(1'b1);
        repeat (10) cyc(1'b0);
        chk("t5_n_out", 16'(n_out), 16'd8);
        chk("t5_n_last", 16'(n_last), 16'd1);
        chk("t5_n_done", 16'(n_done), 16'd1);

`ifdef SDF_SCHED_STATS_EN
        // three frames with a 4-cycle bubble inside the second
        do_reset();
        reset_counts();
        repeat (11) cyc(1'b1);
        repeat (4) cyc(1'b0);
        repeat (13) cyc(1'b1);
        repeat (10) cyc(1'b0);
        chk("t6_frame_cnt", o_frame_cnt, 16'd3);
        chk("t6_stall_cnt", o_stall_cnt, 16'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
